// File: rtl/keypad_pkg.sv
// Shared types and register map for the keypad controller: FSM states,
// register offsets from BASE, and STATUS/CTRL bit positions.
package keypad_pkg;

   typedef enum logic [1:0] {
      POLL    = 2'd0,
      FETCH   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam logic [15:0] OFS_DATA   = 16'd0;
   localparam logic [15:0] OFS_STATUS = 16'd1;
   localparam logic [15:0] OFS_CTRL   = 16'd2;

   localparam int FULL_BIT       = 4;
   localparam int COUNT_LSB      = 0;
   localparam int CTRL_FLUSH_BIT = 0;

endpackage

// File: rtl/key_fifo.sv
// Synchronous key-code FIFO with push, pop and flush; flush overrides both.
// count_nxt exposes the post-edge occupancy so callers can register flags off it.
module key_fifo #(
   parameter int DEPTH = 4,
   parameter int KEYW  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [KEYW-1:0]          din,
   input  logic                     pop,
   input  logic                     flush,
   output logic [KEYW-1:0]          head,
   output logic [$clog2(DEPTH):0]   count,
   output logic [$clog2(DEPTH):0]   count_nxt,
   output logic                     full,
   output logic                     empty
);
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [KEYW-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            do_push, do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (flush)
         count_nxt = '0;
      else if (do_push && !do_pop)
         count_nxt = count + CNT_ONE;
      else if (!do_push && do_pop)
         count_nxt = count - CNT_ONE;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         count <= count_nxt;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/keypad_ctrl.sv
// Autonomous keypad handshake sequencer with a key FIFO exposed to the CPU
// as DATA/STATUS/CTRL registers at BASE.
module keypad_ctrl
   import keypad_pkg::*;
#(
   parameter logic [15:0] BASE  = 16'h0900,
   parameter int          DEPTH = 4,
   parameter int          KEYW  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [15:0] data_wr,
   input  logic        memwt,
   output logic [15:0] rd_data,
   output logic        hit,
   output logic        ack,
   output logic        statusordata,
   input  logic [15:0] keyout,
   output logic        irq
);
   localparam int CW = $clog2(DEPTH) + 1;

   state_t          state, state_nxt;
   logic            ready_p0;
   logic            pop_armed;
   logic [15:0]     offset;
   logic            is_data, is_ctrl;
   logic            push, pop, flush;
   logic [KEYW-1:0] head;
   logic [CW-1:0]   count, count_nxt;
   logic            full, empty;
   logic            unused;

   assign unused  = ^{data_wr[15:1], keyout[15:KEYW]};

   assign offset  = address - BASE;
   assign hit     = (offset <= OFS_CTRL);
   assign is_data = hit && (offset == OFS_DATA);
   assign is_ctrl = hit && (offset == OFS_CTRL);
   assign push    = (state == FETCH);
   assign pop     = is_data && pop_armed && !empty;
   assign flush   = memwt && is_ctrl && data_wr[CTRL_FLUSH_BIT];

   key_fifo #(.DEPTH(DEPTH), .KEYW(KEYW)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .din       (keyout[KEYW-1:0]),
      .pop       (pop),
      .flush     (flush),
      .head      (head),
      .count     (count),
      .count_nxt (count_nxt),
      .full      (full),
      .empty     (empty)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         POLL:    if (ready_p0 && !full) state_nxt = FETCH;
         FETCH:   state_nxt = RELEASE;
         RELEASE: if (!ready_p0) state_nxt = POLL;
         default: state_nxt = POLL;
      endcase
   end

   // ready_p0 only tracks keyout[0] while the keypad is presenting status;
   // during FETCH keyout carries the code, so the last status is held.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= POLL;
         ready_p0     <= 1'b0;
         ack          <= 1'b0;
         statusordata <= 1'b1;
         pop_armed    <= 1'b1;
         irq          <= 1'b0;
      end else begin
         state        <= state_nxt;
         ack          <= (state_nxt == FETCH);
         statusordata <= (state_nxt != FETCH);
         if (statusordata)
            ready_p0 <= keyout[0];
         if (!is_data)
            pop_armed <= 1'b1;
         else if (pop)
            pop_armed <= 1'b0;
         irq          <= (count_nxt != '0);
      end
   end

   always_comb begin
      rd_data = '0;
      if (hit) begin
         case (offset)
            OFS_DATA:   if (!empty) rd_data[KEYW-1:0] = head;
            OFS_STATUS: begin
               rd_data[FULL_BIT]       = full;
               rd_data[COUNT_LSB +: 4] = 4'(count);
            end
            default:    rd_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_ctrl.sv
// Bench for keypad_ctrl: a behavioural keypad plus a queue model of the
// FIFO contents, driven by directed and randomised scenarios.
module tb_keypad_ctrl;
   localparam logic [15:0] A_DATA = 16'h0900;
   localparam logic [15:0] A_STAT = 16'h0901;
   localparam logic [15:0] A_CTRL = 16'h0902;
   localparam int          DEPTH  = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] address = 16'h0000;
   logic [15:0] data_wr = 16'h0000;
   logic        memwt = 1'b0;
   logic [15:0] rd_data;
   logic        hit, ack, statusordata, irq;
   logic [15:0] keyout;

   logic        key_ready = 1'b0;
   logic [3:0]  key_code = 4'h0;

   int          checks = 0;
   int          errors = 0;
   logic [3:0]  ref_q[$];
   logic [3:0]  kp_q[$];
   bit          auto_clear = 1'b1;
   bit          armed_m = 1'b1;
   int          gap = 0;
   int          ack_cnt = 0;
   int          max_size = 0;

   assign keyout = statusordata ? {15'b0, key_ready} : {12'b0, key_code};

   keypad_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .address      (address),
      .data_wr      (data_wr),
      .memwt        (memwt),
      .rd_data      (rd_data),
      .hit          (hit),
      .ack          (ack),
      .statusordata (statusordata),
      .keyout       (keyout),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic refresh_key();
      key_ready = (kp_q.size() != 0) && (gap == 0);
      key_code  = (kp_q.size() != 0) ? kp_q[0] : 4'h0;
   endtask

   // One clock: sample the pre-edge view, advance, then update the models.
   task automatic tick();
      logic       a, rst_s, fl, pp;
      logic [3:0] c;
      a     = ack;
      c     = key_code;
      rst_s = reset;
      fl    = memwt && (address == A_CTRL) && data_wr[0];
      pp    = (address == A_DATA) && armed_m && (ref_q.size() != 0);
      @(posedge clk);
      #1;
      if (rst_s) begin
         ref_q.delete();
         armed_m = 1'b1;
      end else begin
         if (fl) ref_q.delete();
         else begin
            if (pp) void'(ref_q.pop_front());
            if (a) ref_q.push_back(c);
         end
         armed_m = (address != A_DATA) ? 1'b1 : (pp ? 1'b0 : armed_m);
         if (a) ack_cnt++;
      end
      if (ref_q.size() > max_size) max_size = ref_q.size();
      if (gap > 0) gap--;
      if (a && auto_clear && kp_q.size() != 0) begin
         void'(kp_q.pop_front());
         gap = 2;
      end
      refresh_key();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", ack); end
      checks++; if (statusordata !== 1'b1) begin errors++; $display("FAIL reset_sod got %b exp 1", statusordata); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
      address = A_STAT; #1;
      checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL reset_status got %h exp 0000", rd_data); end
      address = A_DATA; #1;
      checks++; if (rd_data !== 16'h0000 || hit !== 1'b1) begin errors++; $display("FAIL reset_data got %h hit %b exp 0000 hit 1", rd_data, hit); end
      address = 16'h0903; #1;
      checks++; if (hit !== 1'b0 || rd_data !== 16'h0000) begin errors++; $display("FAIL miss_hi hit %b rd %h exp 0 0000", hit, rd_data); end
      address = 16'h08FF; #1;
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_lo hit %b exp 0", hit); end
      address = A_CTRL; #1;
      checks++; if (hit !== 1'b1 || rd_data !== 16'h0000) begin errors++; $display("FAIL ctrl_read hit %b rd %h exp 1 0000", hit, rd_data); end
      address = 16'h0000;
      tick();
   endtask

   task automatic test_single();
      int n, a0;
      auto_clear = 1'b0;
      kp_q.push_back(4'hA);
      refresh_key();
      n = 0;
      while (ack !== 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (n != 2) begin errors++; $display("FAIL single_ack_latency got %0d exp 2", n); end
      tick();
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL single_ack_width got %b exp 0", ack); end
      a0 = ack_cnt;
      repeat (5) tick();
      checks++; if (ack_cnt != a0) begin errors++; $display("FAIL single_no_repeat got %0d acks exp 0", ack_cnt - a0); end
      kp_q.delete();
      refresh_key();
      auto_clear = 1'b1;
      repeat (3) tick();
      address = A_STAT; #1;
      checks++; if (rd_data !== 16'h0001) begin errors++; $display("FAIL single_status got %h exp 0001", rd_data); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL single_irq got %b exp 1", irq); end
      address = A_DATA;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (rd_data !== ((i == 0) ? 16'h000A : 16'h0000)) begin
            errors++; $display("FAIL single_read%0d got %h exp %h", i, rd_data, (i == 0) ? 16'h000A : 16'h0000);
         end
         tick();
      end
      address = A_STAT; #1;
      checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL single_after got %h exp 0000", rd_data); end
      address = 16'h0000;
      tick();
   endtask

   task automatic test_back_to_back();
      int n;
      kp_q.push_back(4'h3);
      kp_q.push_back(4'h9);
      refresh_key();
      n = 0;
      while (ref_q.size() < 2 && n < 60) begin tick(); n++; end
      checks++; if (n >= 60) begin errors++; $display("FAIL b2b_timeout got %0d entries exp 2", ref_q.size()); end
      address = A_DATA;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (rd_data !== ((i == 0) ? 16'h0003 : 16'h0009)) begin
            errors++; $display("FAIL b2b_read%0d got %h exp %h", i, rd_data, (i == 0) ? 16'h0003 : 16'h0009);
         end
         tick();
      end
      address = A_STAT; #1;
      checks++; if (rd_data !== 16'h0001) begin errors++; $display("FAIL b2b_status got %h exp 0001", rd_data); end
      tick();
      address = A_DATA; #1;
      checks++; if (rd_data !== 16'h0009) begin errors++; $display("FAIL b2b_rearm got %h exp 0009", rd_data); end
      tick();
      address = 16'h0000;
      tick();
   endtask

   task automatic test_fill();
      int n, a0;
      logic [3:0] exp_d [4] = '{4'h2, 4'h3, 4'h4, 4'h5};
      for (int k = 1; k <= 4; k++) kp_q.push_back(4'(k));
      refresh_key();
      n = 0;
      while (ref_q.size() < 4 && n < 100) begin tick(); n++; end
      tick();
      address = A_STAT; #1;
      checks++; if (rd_data !== 16'h0014) begin errors++; $display("FAIL fill_status got %h exp 0014", rd_data); end
      kp_q.push_back(4'h5);
      refresh_key();
      a0 = ack_cnt;
      repeat (6) tick();
      checks++; if (ack_cnt != a0) begin errors++; $display("FAIL fill_backpressure got %0d acks exp 0", ack_cnt - a0); end
      address = A_DATA; #1;
      checks++; if (rd_data !== 16'h0001) begin errors++; $display("FAIL fill_pop got %h exp 0001", rd_data); end
      tick();
      address = 16'h0000;
      n = 0;
      while (ack !== 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (n > 2) begin errors++; $display("FAIL fill_refetch got %0d cycles exp <=2", n); end
      tick();
      address = A_STAT; #1;
      checks++; if (rd_data !== 16'h0014) begin errors++; $display("FAIL fill_refull got %h exp 0014", rd_data); end
      for (int i = 0; i < 4; i++) begin
         address = A_DATA; #1;
         checks++; if (rd_data !== {12'b0, exp_d[i]}) begin errors++; $display("FAIL fill_drain%0d got %h exp %h", i, rd_data, {12'b0, exp_d[i]}); end
         tick();
         address = 16'h0000;
         tick();
      end
   endtask

   task automatic test_wrap();
      int n, op, sz;
      logic [3:0]  c1, c2;
      logic [15:0] e;
      c1 = 4'($urandom);
      c2 = 4'($urandom);
      kp_q.push_back(c1);
      refresh_key();
      n = 0;
      while (ref_q.size() < 1 && n < 40) begin tick(); n++; end
      repeat (3) tick();
      kp_q.push_back(c2);
      refresh_key();
      n = 0;
      while (ack !== 1'b1 && n < 40) begin tick(); n++; end
      checks++; if (n >= 40) begin errors++; $display("FAIL wrap_ack_timeout got %0d cycles", n); end
      address = A_DATA; #1;
      checks++; if (rd_data !== {12'b0, c1}) begin errors++; $display("FAIL wrap_simul_read got %h exp %h", rd_data, {12'b0, c1}); end
      tick();
      address = A_STAT; #1;
      checks++; if (rd_data !== 16'h0001) begin errors++; $display("FAIL wrap_simul_count got %h exp 0001", rd_data); end
      tick();
      for (int it = 0; it < 60; it++) begin
         op = $urandom_range(0, 3);
         address = 16'h0000;
         case (op)
            0: begin
               if (kp_q.size() == 0) begin kp_q.push_back(4'($urandom)); refresh_key(); end
            end
            1: begin
               address = A_DATA; #1;
               e = (ref_q.size() != 0) ? {12'b0, ref_q[0]} : 16'h0000;
               checks++; if (rd_data !== e) begin errors++; $display("FAIL wrap_data%0d got %h exp %h", it, rd_data, e); end
            end
            2: begin
               address = A_STAT; #1;
               sz = ref_q.size();
               e = 16'(sz) | ((sz == DEPTH) ? 16'h0010 : 16'h0000);
               checks++; if (rd_data !== e) begin errors++; $display("FAIL wrap_status%0d got %h exp %h", it, rd_data, e); end
            end
            default: ;
         endcase
         checks++; if (irq !== (ref_q.size() != 0)) begin errors++; $display("FAIL wrap_irq%0d got %b exp %b", it, irq, ref_q.size() != 0); end
         tick();
      end
      address = 16'h0000;
      n = 0;
      while ((kp_q.size() != 0 || ack === 1'b1) && n < 60) begin tick(); n++; end
      repeat (2) tick();
      n = 0;
      while (ref_q.size() != 0 && n < 10) begin
         e = {12'b0, ref_q[0]};
         address = A_DATA; #1;
         checks++; if (rd_data !== e) begin errors++; $display("FAIL wrap_drain%0d got %h exp %h", n, rd_data, e); end
         tick();
         address = 16'h0000;
         tick();
         n++;
      end
      address = A_STAT; #1;
      checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL wrap_empty got %h exp 0000", rd_data); end
      checks++; if (max_size > DEPTH) begin errors++; $display("FAIL wrap_maxcount got %0d exp <=%0d", max_size, DEPTH); end
      address = 16'h0000;
      tick();
   endtask

   task automatic test_flush();
      int n;
      kp_q.push_back(4'h8);
      kp_q.push_back(4'hB);
      refresh_key();
      n = 0;
      while (ref_q.size() < 2 && n < 60) begin tick(); n++; end
      repeat (3) tick();
      memwt = 1'b1; address = A_CTRL; data_wr = 16'h0002;
      tick();
      memwt = 1'b0; data_wr = 16'h0000;
      address = A_STAT; #1;
      checks++; if (rd_data !== 16'h0002) begin errors++; $display("FAIL flush_ignore got %h exp 0002", rd_data); end
      address = 16'h0000;
      kp_q.push_back(4'hD);
      refresh_key();
      n = 0;
      while (ack !== 1'b1 && n < 40) begin tick(); n++; end
      checks++; if (n >= 40) begin errors++; $display("FAIL flush_ack_timeout got %0d cycles", n); end
      memwt = 1'b1; address = A_CTRL; data_wr = 16'h0001;
      tick();
      memwt = 1'b0; data_wr = 16'h0000;
      address = A_STAT; #1;
      checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL flush_status got %h exp 0000", rd_data); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL flush_irq got %b exp 0", irq); end
      address = A_DATA; #1;
      checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL flush_data got %h exp 0000", rd_data); end
      address = 16'h0000;
      repeat (5) tick();
      address = A_STAT; #1;
      checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL flush_later got %h exp 0000", rd_data); end
      address = 16'h0000;
      tick();
   endtask

   task automatic test_reset_mid();
      int n, a0;
      auto_clear = 1'b0;
      kp_q.push_back(4'h7);
      refresh_key();
      n = 0;
      while (ack !== 1'b1 && n < 40) begin tick(); n++; end
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (statusordata !== 1'b1 || ack !== 1'b0) begin errors++; $display("FAIL rmid_outputs sod %b ack %b exp 1 0", statusordata, ack); end
      address = A_STAT; #1;
      checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL rmid_empty got %h exp 0000", rd_data); end
      address = 16'h0000;
      a0 = ack_cnt;
      repeat (10) tick();
      checks++; if (ack_cnt - a0 != 1) begin errors++; $display("FAIL rmid_refetch got %0d acks exp 1", ack_cnt - a0); end
      address = A_STAT; #1;
      checks++; if (rd_data !== 16'h0001) begin errors++; $display("FAIL rmid_count got %h exp 0001", rd_data); end
      address = A_DATA; #1;
      checks++; if (rd_data !== 16'h0007) begin errors++; $display("FAIL rmid_data got %h exp 0007", rd_data); end
      tick();
      address = 16'h0000;
      kp_q.delete();
      auto_clear = 1'b1;
      refresh_key();
      repeat (4) tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_fill();
      test_wrap();
      test_flush();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
